// File: rtl/cpu_seq_pkg.sv
// ----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared types for the multi-cycle accumulator-CPU sequencer:
//   seq_state_t  - FSM phase encoding (IDLE/FETCH/DECODE/MEMRD/EXEC)
//   OP_*         - 3-bit opcode values
//   ctrl_t       - bundle of the ten datapath strobes
//   is_mem_op()  - opcodes that read data memory before EXEC
//   exec_ctrl()  - strobe pattern of the EXEC phase for a given opcode
// ----------------------------------------------------------------------------
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEMRD  = 3'd3,
      S_EXEC   = 3'd4
   } seq_state_t;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_LDI   = 3'b101;
   localparam logic [2:0] OP_JMP   = 3'b110;
   localparam logic [2:0] OP_BZ    = 3'b111;

   typedef struct packed {
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_reg;
      logic we;
      logic imm;
      logic alu_reg;
      logic alu_add;
      logic alu_sub;
      logic alu_xor;
   } ctrl_t;

   function automatic logic is_mem_op(input logic [2:0] opc);
      return (opc == OP_LOAD) || (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_XOR);
   endfunction

   function automatic ctrl_t exec_ctrl(input logic [2:0] opc, input logic z);
      ctrl_t c;
      c = '0;
      case (opc)
         OP_LOAD:  begin c.alu_reg = 1'b1; c.load_reg = 1'b1; end
         OP_STORE: c.we = 1'b1;
         OP_ADD:   begin c.alu_add = 1'b1; c.load_reg = 1'b1; end
         OP_SUB:   begin c.alu_sub = 1'b1; c.load_reg = 1'b1; end
         OP_XOR:   begin c.alu_xor = 1'b1; c.load_reg = 1'b1; end
         OP_LDI:   begin c.imm = 1'b1; c.alu_reg = 1'b1; c.load_reg = 1'b1; end
         OP_JMP:   c.load_pc = 1'b1;
         OP_BZ:    c.load_pc = z;
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
// Ports:
//   clock    in        rising-edge clock
//   n_reset  in        asynchronous active-low reset (count -> 0)
//   enable   in        count up by one this cycle
//   count    out CNT_W current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             n_reset,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 8-bit accumulator CPU:
// FETCH -> DECODE -> [MEMRD x MEM_LAT] -> EXEC, with run/halt control and a
// saturating retired-instruction counter.
// Optional feature macro: CPU_SEQ_STEP_EN adds the 'step' input (single-step
// one instruction from IDLE on a rising edge of step).
// Ports:
//   clock, n_reset     clock, asynchronous active-low reset
//   run                continuous fetch/execute while high
//   op [OP_W]          opcode from IR, valid from DECODE onward
//   z_flag             ALU zero flag, sampled on the edge entering EXEC
//   step               (CPU_SEQ_STEP_EN only) single-step request
//   load_IR .. ALU_xor registered datapath strobes
//   halted             high while in IDLE
//   instr_done         high during the EXEC cycle
//   retired [CNT_W]    saturating count of completed instructions
// ----------------------------------------------------------------------------
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             n_reset,
`ifdef CPU_SEQ_STEP_EN
   input  logic             step,
`endif
   input  logic             run,
   input  logic [OP_W-1:0]  op,
   input  logic             z_flag,
   output logic             load_IR,
   output logic             INC_PC,
   output logic             load_PC,
   output logic             load_REG,
   output logic             WE,
   output logic             IMM,
   output logic             ALU_REG,
   output logic             ALU_add,
   output logic             ALU_sub,
   output logic             ALU_xor,
   output logic             halted,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired
);

   localparam bit         HAS_WAIT  = (MEM_LAT > 0);
   localparam logic [1:0] WAIT_INIT = HAS_WAIT ? 2'(MEM_LAT - 1) : 2'd0;

   seq_state_t state_q, state_d;
   logic [1:0] wait_q, wait_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic       step_pulse;
   logic       exec_next;
   logic [2:0] opc;

   assign opc = op[2:0];

`ifdef CPU_SEQ_STEP_EN
   // Only a rising edge of step starts an instruction, so a held step
   // runs exactly one instruction.
   logic step_prev_q;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         step_prev_q <= 1'b0;
      end else begin
         step_prev_q <= step;
      end
   end

   assign step_pulse = step & ~step_prev_q;
`else
   assign step_pulse = 1'b0;
`endif

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         wait_q  <= 2'd0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ctrl_d  = '0;

      case (state_q)
         S_IDLE: begin
            if (run || step_pulse) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (HAS_WAIT && is_mem_op(opc)) begin
               state_d = S_MEMRD;
               wait_d  = WAIT_INIT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_MEMRD: begin
            if (wait_q == 2'd0) state_d = S_EXEC;
            else                wait_d  = wait_q - 2'd1;
         end
         S_EXEC: state_d = run ? S_FETCH : S_IDLE;
         default: begin
            state_d = S_IDLE;
            wait_d  = 2'd0;
         end
      endcase

      // Strobes are registered against the phase being entered, so they
      // line up with the cycle the FSM spends in that phase.
      case (state_d)
         S_FETCH: begin
            ctrl_d.load_ir = 1'b1;
            ctrl_d.inc_pc  = 1'b1;
         end
         S_EXEC:  ctrl_d = exec_ctrl(opc, z_flag);
         default: ctrl_d = '0;
      endcase
   end

   assign exec_next = (state_d == S_EXEC);

   // Counting on entry to EXEC makes retired already include the
   // instruction whose EXEC cycle is currently visible.
   sat_counter #(.CNT_W(CNT_W)) u_retired (
      .clock   (clock),
      .n_reset (n_reset),
      .enable  (exec_next),
      .count   (retired)
   );

   assign load_IR    = ctrl_q.load_ir;
   assign INC_PC     = ctrl_q.inc_pc;
   assign load_PC    = ctrl_q.load_pc;
   assign load_REG   = ctrl_q.load_reg;
   assign WE         = ctrl_q.we;
   assign IMM        = ctrl_q.imm;
   assign ALU_REG    = ctrl_q.alu_reg;
   assign ALU_add    = ctrl_q.alu_add;
   assign ALU_sub    = ctrl_q.alu_sub;
   assign ALU_xor    = ctrl_q.alu_xor;
   assign halted     = (state_q == S_IDLE);
   assign instr_done = (state_q == S_EXEC);

endmodule

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer
// Three sequencer instances (MEM_LAT 1/0/3, CNT_W 16/4/4) share run, z_flag
// and (with CPU_SEQ_STEP_EN) step; each gets its own opcode stream. A model
// per instance tracks "which cycle of which instruction" from the opcode
// table and instruction lengths and predicts strobes and retired count.
// Vector layout: {halted, instr_done, load_IR, INC_PC, load_PC, load_REG,
//                 WE, IMM, ALU_REG, ALU_add, ALU_sub, ALU_xor}
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_sequencer;

   localparam int NI = 3;

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction

   function automatic int cw_of(input int i);
      return (i == 0) ? 16 : 4;
   endfunction

   logic clock = 1'b0;
   logic n_reset;
   logic run;
   logic z_flag;
`ifdef CPU_SEQ_STEP_EN
   logic step;
`endif
   logic [2:0] op [NI];
   logic [NI-1:0][11:0] vec;
   logic [NI-1:0][15:0] ret;

   always #5 clock = ~clock;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = lat_of(gi);
      localparam int CW  = cw_of(gi);
      logic [CW-1:0] r;
      logic w_ir, w_inc, w_lpc, w_lreg, w_we, w_imm, w_areg, w_add, w_sub, w_xor, w_halt, w_done;

      cpu_sequencer #(.OP_W(3), .MEM_LAT(LAT), .CNT_W(CW)) dut (
         .clock      (clock),
         .n_reset    (n_reset),
`ifdef CPU_SEQ_STEP_EN
         .step       (step),
`endif
         .run        (run),
         .op         (op[gi]),
         .z_flag     (z_flag),
         .load_IR    (w_ir),
         .INC_PC     (w_inc),
         .load_PC    (w_lpc),
         .load_REG   (w_lreg),
         .WE         (w_we),
         .IMM        (w_imm),
         .ALU_REG    (w_areg),
         .ALU_add    (w_add),
         .ALU_sub    (w_sub),
         .ALU_xor    (w_xor),
         .halted     (w_halt),
         .instr_done (w_done),
         .retired    (r)
      );

      assign vec[gi] = {w_halt, w_done, w_ir, w_inc, w_lpc, w_lreg, w_we, w_imm,
                        w_areg, w_add, w_sub, w_xor};
      assign ret[gi] = 16'(r);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          busy_m [NI];
   int          age_m  [NI];
   int          len_m  [NI];
   int unsigned ret_m  [NI];
   logic [11:0] exp_v  [NI];
   bit          step_prev_m;

   function automatic logic [11:0] exec_vec(input logic [2:0] o, input logic z);
      logic [11:0] v;
      case (o)
         3'd0: v = 12'b01_00_0100_1000;  // LOAD: load_REG, ALU_REG
         3'd1: v = 12'b01_00_0010_0000;  // STORE: WE
         3'd2: v = 12'b01_00_0100_0100;  // ADD
         3'd3: v = 12'b01_00_0100_0010;  // SUB
         3'd4: v = 12'b01_00_0100_0001;  // XOR
         3'd5: v = 12'b01_00_0101_1000;  // LDI: load_REG, IMM, ALU_REG
         3'd6: v = 12'b01_00_1000_0000;  // JMP
         default: v = z ? 12'b01_00_1000_0000 : 12'b01_00_0000_0000;  // BZ
      endcase
      return v;
   endfunction

   function automatic bit mem_op(input logic [2:0] o);
      return (o == 3'd0) || (o == 3'd2) || (o == 3'd3) || (o == 3'd4);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         busy_m[i] = 1'b0;
         age_m[i]  = 0;
         len_m[i]  = 3;
         ret_m[i]  = 0;
         exp_v[i]  = 12'h800;
      end
      step_prev_m = 1'b0;
   endtask

   // Called right after a rising edge; inputs are those the DUT just sampled.
   task automatic model_step();
      bit step_edge;
      bit was_idle;
      int max_ret;
`ifdef CPU_SEQ_STEP_EN
      step_edge   = step && !step_prev_m;
      step_prev_m = step;
`else
      step_edge = 1'b0;
`endif
      for (int i = 0; i < NI; i++) begin
         max_ret = (1 << cw_of(i)) - 1;
         if (!busy_m[i] || age_m[i] == len_m[i] - 1) begin
            was_idle = !busy_m[i];
            if (run || (was_idle && step_edge)) begin
               busy_m[i] = 1'b1;
               age_m[i]  = 0;
               len_m[i]  = 3 + (mem_op(op[i]) ? lat_of(i) : 0);
            end else begin
               busy_m[i] = 1'b0;
            end
         end else begin
            age_m[i]++;
         end
         if (!busy_m[i]) begin
            exp_v[i] = 12'h800;
         end else if (age_m[i] == 0) begin
            exp_v[i] = 12'h300;
         end else if (age_m[i] == len_m[i] - 1) begin
            exp_v[i] = exec_vec(op[i], z_flag);
            if (ret_m[i] < max_ret) ret_m[i]++;
         end else begin
            exp_v[i] = 12'h000;
         end
      end
   endtask

   task automatic compare_all(input string what);
      for (int i = 0; i < NI; i++) begin
         check_eq($sformatf("%s_ctrl%0d", what, i), 16'(vec[i]), 16'(exp_v[i]));
         check_eq($sformatf("%s_retired%0d", what, i), ret[i], 16'(ret_m[i]));
      end
   endtask

   bit force_add = 1'b0;

   task automatic drive_inputs();
      if ($urandom_range(0, 7) == 0) run = ~run;
      z_flag = 1'($urandom_range(0, 1));
`ifdef CPU_SEQ_STEP_EN
      if ($urandom_range(0, 3) == 0) step = ~step;
`endif
      for (int i = 0; i < NI; i++) begin
         // Opcode changes only where the next edge may begin a new instruction.
         if (!busy_m[i] || age_m[i] == len_m[i] - 1) begin
            op[i] = (force_add && i == 0) ? 3'd2 : 3'($urandom_range(0, 7));
         end
      end
   endtask

   task automatic one_cycle(input string what);
      drive_inputs();
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all(what);
   endtask

   initial begin
      bit found;
      n_reset = 1'b0;
      run     = 1'b0;
      z_flag  = 1'b0;
`ifdef CPU_SEQ_STEP_EN
      step    = 1'b0;
`endif
      for (int i = 0; i < NI; i++) op[i] = 3'd0;
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      compare_all("reset");
      n_reset = 1'b1;
      run     = 1'b1;

      for (int k = 0; k < 2000; k++) one_cycle("rand");

      // Reset asserted in the middle of the EXEC cycle of an ADD.
      force_add = 1'b1;
      run       = 1'b1;
      found     = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         one_cycle("pre_rst");
         if (busy_m[0] && age_m[0] == len_m[0] - 1 && op[0] == 3'd2) found = 1'b1;
      end
      check_eq("exec_add_seen", 16'(found), 16'd1);
      #2 n_reset = 1'b0;
      model_reset();
      #1 compare_all("rst_mid_exec");
      @(posedge clock);
      @(negedge clock);
      compare_all("rst_hold");
      n_reset   = 1'b1;
      force_add = 1'b0;

      for (int k = 0; k < 600; k++) one_cycle("post");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
